apb_controller: RTL and testbench

APB-side controller of the AHB-APB bridge. It sits downstream of the AHB slave interface, which supplies `valid`, the address-phase signals and the 3-bit one-hot peripheral select. It converts each accepted AHB transfer into one APB SETUP/ACCESS sequence and stretches the AHB data phase via `h_readyout`. It returns read data and OKAY/ERROR responses, including PSLVERR, timeout and unmapped-address errors.

---
 rtl/apb_bridge_pkg.sv | 31 +++
 rtl/apb_controller_timeout.sv | 30 +++
 rtl/apb_controller.sv | 131 +++++++++++++
 tb/tb_apb_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_bridge_pkg.sv
// Shared types and constants for the AHB-to-APB bridge.
// Imported by the APB-side controller and its timeout counter.
package apb_bridge_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WWAIT,
        SETUP,
        ACCESS,
        ERR1,
        ERR2
    } apb_state_e;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] SLOT_NONE = 3'b000;
    localparam logic [2:0] SLOT_0    = 3'b001;
    localparam logic [2:0] SLOT_1    = 3'b010;
    localparam logic [2:0] SLOT_2    = 3'b100;

    function automatic logic is_onehot3(input logic [2:0] s);
        return (s == SLOT_0) || (s == SLOT_1) || (s == SLOT_2);
    endfunction

endpackage

// File: rtl/apb_controller_timeout.sv
// Saturating wait-state counter for the APB ACCESS phase.
// expired fires on the wait cycle that brings the count up to TIMEOUT.
module apb_timeout_counter #(
    parameter int TIMEOUT = 16
) (
    input  logic h_clk,
    input  logic h_reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [CW-1:0] count;

    always_ff @(posedge h_clk or posedge h_reset) begin
        if (h_reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

    assign expired = (TIMEOUT > 0) && enable && (count == LAST);

endmodule

// File: rtl/apb_controller.sv
// APB-side controller: turns accepted AHB transfers into APB SETUP/ACCESS
// sequences and stretches the AHB data phase through h_readyout.
module apb_controller
    import apb_bridge_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
) (
    input  logic              h_clk,
    input  logic              h_reset,
    input  logic              valid,
    input  logic              h_write,
    input  logic [ADDR_W-1:0] h_addr,
    input  logic [DATA_W-1:0] h_wdata,
    input  logic [2:0]        tempsel,
    input  logic [DATA_W-1:0] p_rdata,
    input  logic              p_ready,
    input  logic              p_slverr,
    output logic [2:0]        p_sel,
    output logic              p_enable,
    output logic              p_write,
    output logic [ADDR_W-1:0] p_addr,
    output logic [DATA_W-1:0] p_wdata,
    output logic              h_readyout,
    output logic [1:0]        h_resp,
    output logic [DATA_W-1:0] h_rdata
);

    apb_state_e state;
    apb_state_e accept_state;
    logic [2:0] sel_q;
    logic [2:0] accept_sel;
    logic       accept;
    logic       mapped;
    logic       expired;

    assign accept = valid & h_readyout;
    assign mapped = is_onehot3(tempsel);

    // Reads go straight to SETUP, so PSEL must come up with the state.
    assign accept_state = !mapped ? ERR1 : (h_write ? WWAIT : SETUP);
    assign accept_sel   = (mapped && !h_write) ? tempsel : SLOT_NONE;

    apb_timeout_counter #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .h_clk   (h_clk),
        .h_reset (h_reset),
        .clear   (state != ACCESS),
        .enable  ((state == ACCESS) && !p_ready),
        .expired (expired)
    );

    always_comb begin
        h_readyout = 1'b0;
        h_resp     = HRESP_OKAY;
        unique case (state)
            IDLE: h_readyout = 1'b1;
            ACCESS: begin
                h_readyout = p_ready & ~p_slverr;
                if (p_ready && p_slverr) h_resp = HRESP_ERROR;
            end
            ERR1: h_resp = HRESP_ERROR;
            ERR2: begin
                h_readyout = 1'b1;
                h_resp     = HRESP_ERROR;
            end
            default: ;
        endcase
    end

    assign h_rdata = (state == ACCESS && !p_write && p_ready) ? p_rdata : '0;

    always_ff @(posedge h_clk or posedge h_reset) begin
        if (h_reset) begin
            state    <= IDLE;
            sel_q    <= SLOT_NONE;
            p_sel    <= SLOT_NONE;
            p_enable <= 1'b0;
            p_write  <= 1'b0;
            p_addr   <= '0;
            p_wdata  <= '0;
        end else begin
            if (accept) begin
                p_addr  <= h_addr;
                p_write <= h_write;
                sel_q   <= tempsel;
            end
            unique case (state)
                IDLE, ERR2: begin
                    state    <= accept ? accept_state : IDLE;
                    p_sel    <= accept ? accept_sel : SLOT_NONE;
                    p_enable <= 1'b0;
                end
                WWAIT: begin
                    p_wdata <= h_wdata;
                    p_sel   <= sel_q;
                    state   <= SETUP;
                end
                SETUP: begin
                    p_enable <= 1'b1;
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (p_ready) begin
                        p_enable <= 1'b0;
                        if (p_slverr) begin
                            p_sel <= SLOT_NONE;
                            state <= ERR2;
                        end else begin
                            p_sel <= accept ? accept_sel : SLOT_NONE;
                            state <= accept ? accept_state : IDLE;
                        end
                    end else if (expired) begin
                        p_sel    <= SLOT_NONE;
                        p_enable <= 1'b0;
                        state    <= ERR1;
                    end
                end
                ERR1: state <= ERR2;
                default: begin
                    p_sel    <= SLOT_NONE;
                    p_enable <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_controller.sv
// Scoreboard bench for apb_controller: random AHB transfers, a reactive
// APB slave, and a monitor checking against a transfer-level model.
module tb_apb_controller;
    import apb_bridge_pkg::*;

    localparam int TO    = 4;
    localparam int NRAND = 150;
    localparam int LIMIT = 20000;

    logic        h_clk = 1'b0;
    logic        h_reset = 1'b1;
    logic        valid = 1'b0;
    logic        h_write = 1'b0;
    logic [31:0] h_addr = '0;
    logic [31:0] h_wdata = '0;
    logic [2:0]  tempsel = '0;
    logic [31:0] p_rdata = '0;
    logic        p_ready = 1'b0;
    logic        p_slverr = 1'b0;
    logic [2:0]  p_sel;
    logic        p_enable;
    logic        p_write;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        h_readyout;
    logic [1:0]  h_resp;
    logic [31:0] h_rdata;

    apb_controller #(
        .TIMEOUT (TO),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .h_clk      (h_clk),
        .h_reset    (h_reset),
        .valid      (valid),
        .h_write    (h_write),
        .h_addr     (h_addr),
        .h_wdata    (h_wdata),
        .tempsel    (tempsel),
        .p_rdata    (p_rdata),
        .p_ready    (p_ready),
        .p_slverr   (p_slverr),
        .p_sel      (p_sel),
        .p_enable   (p_enable),
        .p_write    (p_write),
        .p_addr     (p_addr),
        .p_wdata    (p_wdata),
        .h_readyout (h_readyout),
        .h_resp     (h_resp),
        .h_rdata    (h_rdata)
    );

    always #5 h_clk = ~h_clk;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [2:0]  sel;
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
        int          gap;
    } stim_t;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [2:0]  sel;
    } apb_exp_t;

    typedef struct {
        int          waits;
        logic        slverr;
        logic [31:0] rdata;
    } plan_t;

    typedef struct {
        logic        write;
        logic        err;
        logic [31:0] rdata;
        int          lat;
    } ahb_exp_t;

    stim_t    stim[$];
    apb_exp_t apb_q[$];
    plan_t    plan_q[$];
    ahb_exp_t ahb_q[$];

    int checks = 0;
    int errors = 0;
    bit mon_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Data-phase length and response derived from the transfer's own fate.
    function automatic ahb_exp_t model(input stim_t s);
        ahb_exp_t e;
        int base;
        e.write = s.write;
        e.rdata = s.rdata;
        e.err   = 1'b1;
        e.lat   = 2;
        if ($countones(s.sel) == 1) begin
            base = s.write ? 2 : 1;
            if (s.waits >= TO) begin
                e.lat = base + TO + 2;
            end else if (s.slverr) begin
                e.lat = base + s.waits + 2;
            end else begin
                e.err = 1'b0;
                e.lat = base + s.waits + 1;
            end
        end
        return e;
    endfunction

    function automatic stim_t mk(input logic [31:0] addr, input logic wr,
                                 input logic [31:0] wd, input logic [2:0] sel,
                                 input int waits, input logic serr,
                                 input logic [31:0] rd, input int gap);
        stim_t s;
        s.addr = addr; s.write = wr; s.wdata = wd; s.sel = sel;
        s.waits = waits; s.slverr = serr; s.rdata = rd; s.gap = gap;
        return s;
    endfunction

    task automatic present(input stim_t s);
        apb_exp_t a;
        plan_t    p;
        valid   = 1'b1;
        h_addr  = s.addr;
        h_write = s.write;
        tempsel = s.sel;
        if ($countones(s.sel) == 1) begin
            a.addr = s.addr; a.write = s.write; a.wdata = s.wdata; a.sel = s.sel;
            apb_q.push_back(a);
            p.waits = s.waits; p.slverr = s.slverr; p.rdata = s.rdata;
            plan_q.push_back(p);
        end
        ahb_q.push_back(model(s));
    endtask

    task automatic idle_junk();
        valid   = 1'b0;
        h_addr  = $urandom;
        h_write = 1'($urandom);
        tempsel = 3'($urandom);
    endtask

    // Reactive APB slave following the per-transfer plan.
    plan_t pl;
    bit    have_pl = 1'b0;
    int    acnt = 0;

    always begin
        @(negedge h_clk);
        p_ready  = 1'($urandom);
        p_slverr = 1'($urandom);
        p_rdata  = $urandom;
        if (p_sel != 3'b000 && !p_enable) begin
            have_pl = plan_q.size() > 0;
            if (have_pl) pl = plan_q.pop_front();
            acnt = 0;
        end else if (p_enable) begin
            if (have_pl && acnt >= pl.waits) begin
                p_ready  = 1'b1;
                p_slverr = pl.slverr;
                p_rdata  = pl.rdata;
            end else begin
                p_ready = 1'b0;
            end
            acnt++;
        end
    end

    // Monitor: samples one time unit before each rising edge.
    apb_exp_t   cur;
    ahb_exp_t   e;
    bit         have_cur = 1'b0;
    bit         dp = 1'b0;
    int         dp_cnt = 0;
    logic       prev_ready = 1'b1;
    logic [1:0] prev_resp = 2'b00;

    always begin
        @(negedge h_clk);
        #4;
        if (mon_en) begin
            check("psel_onehot0", 64'($countones(p_sel) <= 1), 64'd1);
            check("penable_without_psel", 64'(p_enable && p_sel == 3'b000), 64'd0);
            if (p_sel != 3'b000 && !p_enable) begin
                check("apb_expected", 64'(apb_q.size() > 0), 64'd1);
                have_cur = apb_q.size() > 0;
                if (have_cur) cur = apb_q.pop_front();
            end
            if (p_sel != 3'b000 && have_cur) begin
                check("p_addr", 64'(p_addr), 64'(cur.addr));
                check("p_write", 64'(p_write), 64'(cur.write));
                check("p_sel", 64'(p_sel), 64'(cur.sel));
                if (cur.write) check("p_wdata", 64'(p_wdata), 64'(cur.wdata));
            end
            if (!h_readyout && !p_ready) check("h_rdata_idle", 64'(h_rdata), 64'd0);
            if (dp) begin
                dp_cnt++;
                if (h_readyout) begin
                    check("ahb_expected", 64'(ahb_q.size() > 0), 64'd1);
                    if (ahb_q.size() > 0) begin
                        e = ahb_q.pop_front();
                        check("h_resp", 64'(h_resp), e.err ? 64'd1 : 64'd0);
                        check("data_phase_len", 64'(dp_cnt), 64'(e.lat));
                        if (!e.err && !e.write) check("h_rdata", 64'(h_rdata), 64'(e.rdata));
                        if (e.err) check("err_first_cycle", 64'({prev_ready, prev_resp}), 64'd1);
                    end
                    dp = 1'b0;
                end
            end
            if (valid && h_readyout) begin
                dp     = 1'b1;
                dp_cnt = 0;
            end
            prev_ready = h_readyout;
            prev_resp  = h_resp;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int          idx;
        int          gap_left;
        int          cyc;
        bit          acc;
        bit          wd_pend;
        logic [31:0] wd;
        logic [2:0]  s;
        int          w;

        stim.push_back(mk(32'h8000_0010, 0, 0, 3'b001, 0, 0, 32'hDEAD_BEEF, 0));
        stim.push_back(mk(32'h8400_0004, 1, 32'h1234_5678, 3'b010, 0, 0, 0, 2));
        stim.push_back(mk(32'h8800_0008, 1, 32'hA5A5_5A5A, 3'b100, 0, 0, 0, 1));
        stim.push_back(mk(32'h8000_0020, 0, 0, 3'b001, 0, 0, 32'h0BAD_F00D, 0));
        stim.push_back(mk(32'h8400_0030, 1, 32'hCAFE_0001, 3'b010, 3, 0, 0, 1));
        stim.push_back(mk(32'h8400_0034, 0, 0, 3'b010, 3, 0, 32'h5555_AAAA, 1));
        stim.push_back(mk(32'h8800_0040, 1, 32'h0000_00FF, 3'b100, 0, 1, 0, 1));
        stim.push_back(mk(32'h8000_0044, 0, 0, 3'b001, 2, 1, 32'h1111_2222, 0));
        stim.push_back(mk(32'h9000_0000, 0, 0, 3'b000, 0, 0, 0, 1));
        stim.push_back(mk(32'h9000_0004, 1, 32'h7777_7777, 3'b011, 0, 0, 0, 0));
        stim.push_back(mk(32'h8000_0050, 0, 0, 3'b001, 4, 0, 32'h3333_4444, 1));
        stim.push_back(mk(32'h8400_0054, 1, 32'h9999_8888, 3'b010, 5, 0, 0, 0));
        for (int i = 0; i < NRAND; i++) begin
            if ($urandom_range(0, 9) < 8) begin
                s = 3'b001 << $urandom_range(0, 2);
            end else begin
                do s = 3'($urandom); while ($countones(s) == 1);
            end
            w = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 2) : $urandom_range(3, 5);
            stim.push_back(mk($urandom, 1'($urandom), $urandom, s, w,
                              $urandom_range(0, 5) == 0, $urandom,
                              ($urandom_range(0, 3) == 0) ? $urandom_range(1, 2) : 0));
        end

        repeat (3) @(negedge h_clk);
        h_reset = 1'b0;
        #4;
        check("rst_p_sel", 64'(p_sel), 64'd0);
        check("rst_p_enable", 64'(p_enable), 64'd0);
        check("rst_p_write", 64'(p_write), 64'd0);
        check("rst_p_addr", 64'(p_addr), 64'd0);
        check("rst_p_wdata", 64'(p_wdata), 64'd0);
        check("rst_h_readyout", 64'(h_readyout), 64'd1);
        check("rst_h_resp", 64'(h_resp), 64'd0);
        check("rst_h_rdata", 64'(h_rdata), 64'd0);
        mon_en = 1'b1;

        idx = 0; gap_left = -1; cyc = 0; acc = 0; wd_pend = 0; wd = '0;
        while ((idx < stim.size() || ahb_q.size() > 0 || valid) && cyc < LIMIT) begin
            @(negedge h_clk);
            cyc++;
            h_wdata = wd_pend ? wd : $urandom;
            wd_pend = 1'b0;
            if (acc) begin
                valid = 1'b0;
                acc   = 1'b0;
            end
            if (!valid) begin
                if (idx < stim.size()) begin
                    if (gap_left < 0) gap_left = stim[idx].gap;
                    if (gap_left > 0) begin
                        gap_left--;
                        idle_junk();
                    end else begin
                        present(stim[idx]);
                        gap_left = -1;
                    end
                end else begin
                    idle_junk();
                end
            end
            #4;
            if (valid && h_readyout) begin
                acc     = 1'b1;
                wd_pend = stim[idx].write;
                wd      = stim[idx].wdata;
                idx++;
            end
        end
        check("all_issued", 64'(idx), 64'(stim.size()));
        check("all_responded", 64'(ahb_q.size()), 64'd0);

        // Asynchronous reset in the middle of an ACCESS phase.
        repeat (2) @(negedge h_clk);
        mon_en = 1'b0;
        plan_q.delete();
        @(negedge h_clk);
        valid   = 1'b1;
        h_write = 1'b0;
        h_addr  = 32'h8C00_0040;
        tempsel = 3'b100;
        plan_q.push_back('{waits: 9, slverr: 1'b0, rdata: 32'h0});
        @(negedge h_clk);
        valid = 1'b0;
        @(negedge h_clk);
        #1;
        check("pre_rst_access", 64'({p_sel, p_enable}), 64'({3'b100, 1'b1}));
        #1;
        h_reset = 1'b1;
        #1;
        check("mid_rst_p_sel", 64'(p_sel), 64'd0);
        check("mid_rst_p_enable", 64'(p_enable), 64'd0);
        check("mid_rst_p_addr", 64'(p_addr), 64'd0);
        check("mid_rst_h_readyout", 64'(h_readyout), 64'd1);
        check("mid_rst_h_resp", 64'(h_resp), 64'd0);
        check("mid_rst_h_rdata", 64'(h_rdata), 64'd0);
        @(negedge h_clk);
        h_reset = 1'b0;
        repeat (2) @(negedge h_clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
